serial_frame_tx: RTL and testbench
==================================

# serial_frame_tx

Parametrised, single-clock successor to the serial transceiver: buffers parallel words in a small FIFO and streams each word out SBITI bits per beat at a programmable beat rate, MSB- or LSB-first, with gapless back-to-back frames. Sits between the calculator's result path and the serial link, replacing the separate transmit clock with an internal beat divider.

## Interface
- SBITI, 3: bits per beat (lane width), ≥1
- DinLENGTH, 32: word width; NBEATS = ceil(DinLENGTH/SBITI)
- DIV, 4: Clk cycles per beat, ≥1
- DEPTH, 4: FIFO depth in words, power of two, ≥2
- MSB_FIRST, 1: 1 = MSB-first, 0 = LSB-first
- Clk  input  1  sole clock, rising edge
- Reset  input  1  synchronous, active-low reset
- DataIn  input  DinLENGTH  word to enqueue
- Sample  input  1  enqueue strobe; accepted when Full=0
- StartTx  input  1  level enable; new frames launch only while high
- Dout  output  SBITI  current beat; high-Z when not transmitting
- DoutValid  output  1  high while Dout carries a beat
- TxBusy  output  1  high while a frame is in flight
- TxDone  output  1  one-cycle pulse per completed frame
- Full  output  1  FIFO holds DEPTH words
- Count  output  $clog2(DEPTH+1)  FIFO fill level
- Overflow  output  1  one-cycle pulse: Sample while Full (word dropped)

## Operation
- Reset values: Dout=Z, DoutValid=0, TxBusy=0, TxDone=0, Full=0, Count=0, Overflow=0; FIFO emptied, FSM in IDLE, divider and beat counter 0.
- FSM states: IDLE, SHIFT, PARITY (PARITY exists only with macro, see Configuration).
- IDLE: if StartTx=1 and Count>0, pop head into shift register, go SHIFT; else stay, Dout=Z.
- SHIFT: Dout = current beat, held DIV cycles; beat counter increments at divider wrap. After beat NBEATS-1 ends: go PARITY (if enabled) else end-of-frame.
- End-of-frame: TxDone pulses; if StartTx=1 and Count>0, pop next word and stay SHIFT with beat 0 in the very next cycle (no gap); else IDLE.
- StartTx falling mid-frame does not abort; current frame completes, then IDLE.
- Beat ordering: MSB_FIRST=1: beat k = word bits [DinLENGTH-1-k·SBITI -: SBITI]; final partial beat zero-padded in its low bits. MSB_FIRST=0: beat k = bits [k·SBITI +: SBITI]; final partial beat zero-padded in its high bits.
- FIFO: Sample with Full=0 writes; Sample with Full=1 drops the word and pulses Overflow, even if a pop occurs the same cycle. Pop and push on same cycle with 0<Count<DEPTH: Count unchanged. Pop never sees a word written in the same cycle.
- Count, Full registered; pointers wrap modulo DEPTH.

## Timing
- Sample at edge n → word visible (Count++) after edge n; if IDLE with StartTx=1, first beat on Dout after edge n+1.
- Frame length: NBEATS·DIV cycles (plus DIV with parity). DoutValid=TxBusy=1 throughout.
- TxDone asserted in the cycle following the last beat's final cycle; coincides with beat 0 of the next frame when gapless, else with IDLE (Dout=Z, TxBusy=0).
- Reset=0 at any edge, including mid-frame: all state to reset values at that edge; no TxDone pulse; queued words lost.

## Configuration
- SERIAL_TX_PARITY_EN defined: after last data beat, one extra beat of DIV cycles: Dout = {(SBITI-1)'b0, even parity (XOR) of the full DinLENGTH word}; TxDone follows this beat.
- Undefined: no PARITY state, frame is exactly NBEATS beats.

## Structure
- Package serial_tx_pkg: state enum (IDLE, SHIFT, PARITY), function nbeats(DinLENGTH, SBITI), function to compute Count width.
- Sub-module serial_tx_fifo (DEPTH × DinLENGTH, push/pop/Count/Full/Overflow); FSM, divider and shifter in serial_frame_tx.

## Test plan
- Defaults, Sample 0xDEADBEEF, StartTx=1 → 11 beats of 4 cycles, first Dout=3'b110, last Dout=3'b110, TxDone 44 cycles after first beat, then Dout=Z.
- MSB_FIRST=0, same word → first beat 3'b111, last beat {pad 0, bits[31:30]=2'b11}=3'b011.
- Push 4 words with StartTx=0, 5th Sample → Full=1, Overflow pulse, Count=4; raise StartTx → 4 gapless frames, 4 TxDone pulses, Dout never Z between frames.
- Reset=0 at beat 5 of a frame with 2 words queued → next cycle Dout=Z, TxBusy=0, Count=0, no TxDone.
- SERIAL_TX_PARITY_EN, 0xDEADBEEF → 12th beat 3'b000; 0x00000001 → 12th beat 3'b001; TxDone at 48 cycles.
- StartTx dropped at beat 3 with a second word queued → first frame completes, TxDone, IDLE, Count stays 1.

Source files
------------

// File: rtl/serial_tx_pkg.sv
// serial_tx_pkg: shared state codes and sizing helpers for serial_frame_tx.
// No ports; imported by the interface, the FIFO and the top.
package serial_tx_pkg;

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] SHIFT  = 2'd1;
  localparam logic [1:0] PARITY = 2'd2;

  function automatic int nbeats(input int dlen, input int sbiti);
    return (dlen + sbiti - 1) / sbiti;
  endfunction

  function automatic int cnt_w(input int depth);
    return $clog2(depth + 1);
  endfunction

endpackage

// File: rtl/serial_frame_tx_if.sv
// serial_frame_tx_if: word-side bundle of serial_frame_tx.
// master drives DataIn/Sample/StartTx; slave drives status (DoutValid..Overflow).
interface serial_frame_tx_if
  import serial_tx_pkg::*;
#(
  parameter int DinLENGTH = 32,
  parameter int DEPTH     = 4
);

  logic [DinLENGTH-1:0]      DataIn;
  logic                      Sample;
  logic                      StartTx;
  logic                      DoutValid;
  logic                      TxBusy;
  logic                      TxDone;
  logic                      Full;
  logic [cnt_w(DEPTH)-1:0]   Count;
  logic                      Overflow;

  modport master (
    output DataIn, Sample, StartTx,
    input  DoutValid, TxBusy, TxDone,
    input  Full, Count, Overflow
  );

  modport slave (
    input  DataIn, Sample, StartTx,
    output DoutValid, TxBusy, TxDone,
    output Full, Count, Overflow
  );

endinterface

// File: rtl/serial_tx_fifo.sv
// serial_tx_fifo: DEPTH x W word FIFO; ports clk, reset (sync, low), push, pop,
// din, head (combinational head word), count, full, overflow (registered pulse).
module serial_tx_fifo
  import serial_tx_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int W     = 32
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    push,
  input  logic                    pop,
  input  logic [W-1:0]            din,
  output logic [W-1:0]            head,
  output logic [cnt_w(DEPTH)-1:0] count,
  output logic                    full,
  output logic                    overflow
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = cnt_w(DEPTH);

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wptr;
  logic [AW-1:0] rptr;
  logic          wr;
  logic          rd;
  logic [CW-1:0] count_nxt;

  // full is the pre-edge value, so a drop still happens when a pop coincides
  assign wr   = push & ~full;
  assign rd   = pop & (count != '0);
  assign head = mem[rptr];

  always_comb begin
    count_nxt = count;
    if (wr & ~rd)
      count_nxt = count + 1'b1;
    else if (rd & ~wr)
      count_nxt = count - 1'b1;
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      wptr     <= '0;
      rptr     <= '0;
      count    <= '0;
      full     <= 1'b0;
      overflow <= 1'b0;
    end else begin
      if (wr)
        wptr <= wptr + 1'b1;
      if (rd)
        rptr <= rptr + 1'b1;
      count    <= count_nxt;
      full     <= (count_nxt == CW'(DEPTH));
      overflow <= push & full;
    end
  end

  always_ff @(posedge clk) begin
    if (wr)
      mem[wptr] <= din;
  end

endmodule

// File: rtl/serial_frame_tx.sv
// serial_frame_tx: FIFO-buffered word serialiser, SBITI bits per beat, DIV clks per beat.
// Ports: Clk, Reset (sync, low), bus (serial_frame_tx_if.slave), Dout (Z when idle); macro SERIAL_TX_PARITY_EN.
module serial_frame_tx
  import serial_tx_pkg::*;
#(
  parameter int SBITI     = 3,
  parameter int DinLENGTH = 32,
  parameter int DIV       = 4,
  parameter int DEPTH     = 4,
  parameter int MSB_FIRST = 1
) (
  input  logic               Clk,
  input  logic               Reset,
  serial_frame_tx_if.slave   bus,
  output logic [SBITI-1:0]   Dout
);

  localparam int NB = nbeats(DinLENGTH, SBITI);
  localparam int PW = NB * SBITI;
  localparam int DW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int BW = (NB > 1) ? $clog2(NB) : 1;

  logic [1:0]              state;
  logic [DW-1:0]           div_cnt;
  logic [BW-1:0]           beat_cnt;
  logic [PW-1:0]           shreg;
  logic [PW-1:0]           loaded;
  logic [DinLENGTH-1:0]    head;
  logic [cnt_w(DEPTH)-1:0] count;
  logic [SBITI-1:0]        beat;
  logic                    valid;
  logic                    done;
  logic                    wrap;
  logic                    last_beat;
  logic                    frame_end;
  logic                    launch;
`ifdef SERIAL_TX_PARITY_EN
  logic                    par;
`endif

  serial_tx_fifo #(
    .DEPTH (DEPTH),
    .W     (DinLENGTH)
  ) u_fifo (
    .clk      (Clk),
    .reset    (Reset),
    .push     (bus.Sample),
    .pop      (launch),
    .din      (bus.DataIn),
    .head     (head),
    .count    (count),
    .full     (bus.Full),
    .overflow (bus.Overflow)
  );

  assign wrap      = (div_cnt == DW'(DIV - 1));
  assign last_beat = (beat_cnt == BW'(NB - 1));
  assign valid     = (state != IDLE);

`ifdef SERIAL_TX_PARITY_EN
  assign frame_end = (state == PARITY) & wrap;
`else
  assign frame_end = (state == SHIFT) & wrap & last_beat;
`endif

  // a frame end may launch the next word in the same edge: no idle gap
  assign launch = ((state == IDLE) | frame_end)
                & bus.StartTx & (count != '0);

  // word sits at the top (MSB-first) or bottom (LSB-first) of the
  // padded register, so the pad always lands in the final beat
  always_comb begin
    if (MSB_FIRST != 0)
      loaded = PW'(head) << (PW - DinLENGTH);
    else
      loaded = PW'(head);
  end

  always_comb begin
    if (MSB_FIRST != 0)
      beat = shreg[PW-1 -: SBITI];
    else
      beat = shreg[SBITI-1:0];
`ifdef SERIAL_TX_PARITY_EN
    if (state == PARITY)
      beat = SBITI'(par);
`endif
  end

  assign Dout          = valid ? beat : {SBITI{1'bz}};
  assign bus.DoutValid = valid;
  assign bus.TxBusy    = valid;
  assign bus.TxDone    = done;
  assign bus.Count     = count;

  always_ff @(posedge Clk) begin
    if (!Reset) begin
      state    <= IDLE;
      div_cnt  <= '0;
      beat_cnt <= '0;
      shreg    <= '0;
      done     <= 1'b0;
`ifdef SERIAL_TX_PARITY_EN
      par      <= 1'b0;
`endif
    end else begin
      done <= frame_end;
      unique case (1'b1)
        launch: begin
          state    <= SHIFT;
          div_cnt  <= '0;
          beat_cnt <= '0;
          shreg    <= loaded;
`ifdef SERIAL_TX_PARITY_EN
          par      <= ^head;
`endif
        end
        (frame_end & ~launch): begin
          state    <= IDLE;
          div_cnt  <= '0;
          beat_cnt <= '0;
        end
        (valid & ~frame_end): begin
          if (wrap) begin
            div_cnt  <= '0;
            beat_cnt <= beat_cnt + 1'b1;
            if (MSB_FIRST != 0)
              shreg <= shreg << SBITI;
            else
              shreg <= shreg >> SBITI;
`ifdef SERIAL_TX_PARITY_EN
            if ((state == SHIFT) & last_beat)
              state <= PARITY;
`endif
          end else begin
            div_cnt <= div_cnt + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_serial_frame_tx.sv
// tb_serial_frame_tx: directed bench for MSB- and LSB-first serial_frame_tx
// instances against a queue-based frame model; honours SERIAL_TX_PARITY_EN.
module tb_serial_frame_tx;

  localparam int S  = 3;
  localparam int L  = 32;
  localparam int DV = 4;
  localparam int DP = 4;
  localparam int NB = (L + S - 1) / S;
`ifdef SERIAL_TX_PARITY_EN
  localparam int FB = NB + 1;
`else
  localparam int FB = NB;
`endif
  localparam int FL = FB * DV;

  logic         clk    = 1'b0;
  logic         rst_n  = 1'b0;
  logic         sample = 1'b0;
  logic         start  = 1'b0;
  logic [L-1:0] din    = '0;
  wire  [S-1:0] dout1;
  wire  [S-1:0] dout0;

  int tests = 0;
  int fails = 0;
  bit mon_en = 1'b0;

  always #5 clk = ~clk;

  serial_frame_tx_if #(.DinLENGTH(L), .DEPTH(DP)) b1 ();
  serial_frame_tx_if #(.DinLENGTH(L), .DEPTH(DP)) b0 ();

  assign b1.DataIn  = din;
  assign b1.Sample  = sample;
  assign b1.StartTx = start;
  assign b0.DataIn  = din;
  assign b0.Sample  = sample;
  assign b0.StartTx = start;

  serial_frame_tx #(
    .SBITI(S), .DinLENGTH(L), .DIV(DV), .DEPTH(DP), .MSB_FIRST(1)
  ) u_msb (
    .Clk(clk), .Reset(rst_n), .bus(b1), .Dout(dout1)
  );

  serial_frame_tx #(
    .SBITI(S), .DinLENGTH(L), .DIV(DV), .DEPTH(DP), .MSB_FIRST(0)
  ) u_lsb (
    .Clk(clk), .Reset(rst_n), .bus(b0), .Dout(dout0)
  );

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [S-1:0] beat_of(input logic [L-1:0] w,
                                           input int k, input bit msb);
    logic [S-1:0] b;
    int idx;
    b = '0;
    if (k >= NB) begin
      b[0] = ^w;
    end else begin
      for (int j = 0; j < S; j++) begin
        if (msb) begin
          idx = L - 1 - k * S - j;
          if (idx >= 0) b[S-1-j] = w[idx];
        end else begin
          idx = k * S + j;
          if (idx < L) b[j] = w[idx];
        end
      end
    end
    return b;
  endfunction

  logic [L-1:0] mq[$];
  logic [L-1:0] cur;
  int cyc;
  bit busy, m_done, m_ovf;

  initial begin
    busy = 0; cyc = 0; m_done = 0; m_ovf = 0; cur = '0;
    forever begin
      @(posedge clk);
      if (!rst_n) begin
        mq.delete();
        busy = 0; cyc = 0; m_done = 0; m_ovf = 0;
      end else begin
        bit fin;
        bit was_full;
        was_full = (mq.size() == DP);
        fin      = busy && (cyc == FL - 1);
        m_done   = fin;
        m_ovf    = 0;
        if (busy && !fin) cyc++;
        else if (start && mq.size() > 0) begin
          cur  = mq.pop_front();
          cyc  = 0;
          busy = 1;
        end else busy = 0;
        if (sample) begin
          if (was_full) m_ovf = 1;
          else mq.push_back(din);
        end
      end
    end
  end

  initial begin
    forever begin
      @(negedge clk);
      if (mon_en) begin
        chk("valid_msb", b1.DoutValid, busy);
        chk("busy_msb",  b1.TxBusy, busy);
        chk("done_msb",  b1.TxDone, m_done);
        chk("count_msb", b1.Count, mq.size());
        chk("full_msb",  b1.Full, mq.size() == DP);
        chk("ovf_msb",   b1.Overflow, m_ovf);
        chk("valid_lsb", b0.DoutValid, busy);
        chk("done_lsb",  b0.TxDone, m_done);
        chk("count_lsb", b0.Count, mq.size());
        chk("ovf_lsb",   b0.Overflow, m_ovf);
        if (busy) begin
          chk("dout_msb", dout1, beat_of(cur, cyc / DV, 1'b1));
          chk("dout_lsb", dout0, beat_of(cur, cyc / DV, 1'b0));
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #2;
    end
  endtask

  task automatic push(input logic [L-1:0] w);
    din    = w;
    sample = 1'b1;
    tick();
    sample = 1'b0;
  endtask

  initial begin
    int  ndone;
    int  ngap;
    bit  seen;

    rst_n = 1'b0;
    tick(3);
    mon_en = 1'b1;
    chk("rst_count", b1.Count, 0);
    chk("rst_valid", b1.DoutValid, 0);
    chk("rst_done",  b1.TxDone, 0);
    chk("rst_full",  b1.Full, 0);
    chk("rst_ovf",   b1.Overflow, 0);
    rst_n = 1'b1;
    tick();

    din = 32'hDEADBEEF; sample = 1'b1; start = 1'b1;
    tick();
    sample = 1'b0;
    chk("a_queued", b1.Count, 1);
    chk("a_notyet", b1.DoutValid, 0);
    tick();
    chk("a_first_msb", dout1, 3'b110);
    chk("a_first_lsb", dout0, 3'b111);
    chk("a_popped", b1.Count, 0);
    tick(40);
    chk("a_last_msb", dout1, 3'b110);
    chk("a_last_lsb", dout0, 3'b011);
    tick(FL - 41);
    chk("a_nodone", b1.TxDone, 0);
    tick();
    chk("a_done", b1.TxDone, 1);
    chk("a_idle", b1.DoutValid, 0);
    start = 1'b0;
    tick(2);

    push(32'h00000001);
    push(32'hFFFFFFFF);
    push(32'h12345678);
    push(32'hA5A50F0F);
    chk("b_full", b1.Full, 1);
    chk("b_count4", b1.Count, 4);
    push(32'hCAFEF00D);
    chk("b_ovf", b1.Overflow, 1);
    chk("b_count_hold", b1.Count, 4);
    tick();
    chk("b_ovf_pulse", b1.Overflow, 0);
    start = 1'b1;
    ndone = 0;
    ngap  = 0;
    for (int i = 1; i <= 4 * FL + 1; i++) begin
      tick();
      if (b1.TxDone) ndone++;
      if (i <= 4 * FL && !b1.DoutValid) ngap++;
    end
    chk("b_dones", ndone, 4);
    chk("b_gaps", ngap, 0);
    start = 1'b0;
    tick(2);

    push(32'h11111111);
    push(32'h22222222);
    push(32'h33333333);
    start = 1'b1;
    tick();
    tick(20);
    chk("c_busy_b5", b1.TxBusy, 1);
    chk("c_queued", b1.Count, 2);
    rst_n = 1'b0;
    start = 1'b0;
    tick();
    chk("c_valid", b1.DoutValid, 0);
    chk("c_busy", b1.TxBusy, 0);
    chk("c_count", b1.Count, 0);
    chk("c_done", b1.TxDone, 0);
    rst_n = 1'b1;
    tick();
    chk("c_done2", b1.TxDone, 0);
    tick(2);

    push(32'h0F0F0F0F);
    push(32'h87654321);
    start = 1'b1;
    tick();
    tick(12);
    start = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 2 * FL && !seen; i++) begin
      tick();
      if (b1.TxDone) seen = 1'b1;
    end
    chk("d_done_seen", seen, 1);
    chk("d_idle", b1.DoutValid, 0);
    chk("d_count", b1.Count, 1);
    tick(5);
    chk("d_count_hold", b1.Count, 1);
    chk("d_idle_hold", b1.TxBusy, 0);
    start = 1'b1;
    tick(FL + 3);
    start = 1'b0;
    chk("d_drained", b1.Count, 0);
    tick(2);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
